// File: rtl/hls_run_sequencer.sv
// Multi-run controller for a start_port/done_port kernel: resets, starts and times each run,
// enforces a timeout, and logs {cycles, status, run index} into a small result FIFO.
module hls_run_sequencer #(
   parameter int CYC_W      = 32,
   parameter int TIMEOUT    = 200000000,
   parameter int RUNS_W     = 8,
   parameter int RST_CYCLES = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              go,
   input  logic [RUNS_W-1:0] cfg_runs,
   input  logic              abort,
   output logic              busy,
   output logic              all_done,
   output logic              kernel_reset_n,
   output logic              start_port,
   input  logic              done_port,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [CYC_W-1:0]  res_cycles,
   output logic [1:0]        res_status,
   output logic [RUNS_W-1:0] res_run_idx
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ENT_W = CYC_W + 2 + RUNS_W;
   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_TMO = 2'b01;
   localparam logic [1:0] ST_ABT = 2'b10;

   typedef enum logic [2:0] {S_IDLE, S_KRST, S_START, S_WAIT, S_LOG, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [CYC_W-1:0]  cnt_q, cnt_d;
   logic [RUNS_W-1:0] runs_q, runs_d;
   logic [RUNS_W-1:0] idx_q, idx_d;
   logic [1:0]        sts_q, sts_d;
   logic              abt_q, abt_d;

   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]  occ_q;
   logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
   logic              full, push, pop;

   assign full      = (occ_q == OCC_W'(FIFO_DEPTH));
   assign res_valid = (occ_q != '0);
   assign pop       = res_valid & res_ready;
   // A stalled push may complete in the same cycle the consumer frees the head slot.
   assign push      = (state_q == S_LOG) & (!full | pop);
   assign {res_cycles, res_status, res_run_idx} = res_valid ? mem_q[rd_ptr_q] : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         runs_q  <= '0;
         idx_q   <= '0;
         sts_q   <= ST_OK;
         abt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         runs_q  <= runs_d;
         idx_q   <= idx_d;
         sts_q   <= sts_d;
         abt_q   <= abt_d;
      end
   end

   // cnt doubles as the KRST length counter and holds 1 during START, so done seen
   // N cycles after the start cycle reads back as N+1.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      runs_d  = runs_q;
      idx_d   = idx_q;
      sts_d   = sts_q;
      abt_d   = abt_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               if (cfg_runs != '0) begin
                  state_d = S_KRST;
                  runs_d  = cfg_runs;
                  idx_d   = '0;
                  cnt_d   = CYC_W'(1);
                  abt_d   = 1'b0;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_KRST: begin
            if (abort) begin
               state_d = S_DONE;
            end else if (cnt_q == CYC_W'(RST_CYCLES)) begin
               state_d = S_START;
               cnt_d   = CYC_W'(1);
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         S_START: begin
            if (abort) begin
               state_d = S_DONE;
            end else begin
               state_d = S_WAIT;
               cnt_d   = cnt_q + CYC_W'(1);
            end
         end
         S_WAIT: begin
            if (done_port) begin
               state_d = S_LOG;
               sts_d   = ST_OK;
               abt_d   = abort;
            end else if (abort) begin
               state_d = S_LOG;
               sts_d   = ST_ABT;
            end else if (cnt_q == CYC_W'(TIMEOUT)) begin
               state_d = S_LOG;
               sts_d   = ST_TMO;
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         S_LOG: begin
            if (abort) abt_d = 1'b1;
            if (push) begin
               if ((sts_q != ST_OK) || (idx_q == runs_q - RUNS_W'(1)) || abt_q || abort) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_KRST;
                  idx_d   = idx_q + RUNS_W'(1);
                  cnt_d   = CYC_W'(1);
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy           = 1'b0;
      all_done       = 1'b0;
      kernel_reset_n = 1'b0;
      start_port     = 1'b0;
      case (state_q)
         S_KRST:  busy = 1'b1;
         S_START: begin
            busy           = 1'b1;
            kernel_reset_n = 1'b1;
            start_port     = 1'b1;
         end
         S_WAIT, S_LOG: begin
            busy           = 1'b1;
            kernel_reset_n = 1'b1;
         end
         S_DONE: begin
            busy     = 1'b1;
            all_done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= {cnt_q, sts_q, idx_q};
   end

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Randomized bench for hls_run_sequencer: a kernel/consumer model predicts each logged entry
// from the run's planned latency, abort and timeout, and compares it at FIFO pop time.
module tb_hls_run_sequencer;

   localparam int CYC_W      = 16;
   localparam int TIMEOUT    = 20;
   localparam int RUNS_W     = 8;
   localparam int RST_CYCLES = 2;
   localparam int FIFO_DEPTH = 2;

   logic              clock;
   logic              reset;
   logic              go;
   logic [RUNS_W-1:0] cfg_runs;
   logic              abort;
   logic              busy;
   logic              all_done;
   logic              kernel_reset_n;
   logic              start_port;
   logic              done_port;
   logic              res_valid;
   logic              res_ready;
   logic [CYC_W-1:0]  res_cycles;
   logic [1:0]        res_status;
   logic [RUNS_W-1:0] res_run_idx;

   hls_run_sequencer #(
      .CYC_W(CYC_W), .TIMEOUT(TIMEOUT), .RUNS_W(RUNS_W),
      .RST_CYCLES(RST_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clock(clock), .reset(reset), .go(go), .cfg_runs(cfg_runs), .abort(abort),
      .busy(busy), .all_done(all_done), .kernel_reset_n(kernel_reset_n),
      .start_port(start_port), .done_port(done_port), .res_valid(res_valid),
      .res_ready(res_ready), .res_cycles(res_cycles), .res_status(res_status),
      .res_run_idx(res_run_idx)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      int cycles;
      int status;
      int idx;
   } ent_t;

   ent_t exp_q[$];
   int   n_pass = 0;
   int   n_chk = 0;
   int   cyc = 0;
   int   done_at = -1;
   int   abort_at = -1;
   int   starts = 0;
   int   batch_runs = 0;
   int   krst_run = -1;
   int   mode = 0;
   int   go_cyc = 0;
   int   low_run = 0;
   bit   end_exp = 1'b0;
   bit   done_seen = 1'b0;
   bit   prev_hold = 1'b0;
   bit   force_ready = 1'b0;
   logic [CYC_W+2+RUNS_W-1:0] prev_head;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_all_done"}, all_done, 0);
      check({tag, "_kernel_reset_n"}, kernel_reset_n, 0);
      check({tag, "_start_port"}, start_port, 0);
      check({tag, "_res_valid"}, res_valid, 0);
      check({tag, "_res_cycles"}, res_cycles, 0);
      check({tag, "_res_status"}, res_status, 0);
      check({tag, "_res_run_idx"}, res_run_idx, 0);
   endtask

   // mode 0: random outcomes; 1: FIFO hold-off, latency 3; 2: abort in KRST; 3: latency 5; 4: timeout
   task automatic plan_run(input int idx);
      int   r;
      int   n;
      int   k;
      ent_t e;
      r = (mode == 0) ? int'($urandom_range(9)) : (mode == 4) ? 0 : 9;
      e.idx = idx;
      done_at = -1;
      abort_at = -1;
      if (r == 0) begin
         e.cycles = TIMEOUT;
         e.status = 1;
         end_exp = 1'b1;
      end else if (r == 1) begin
         k = int'($urandom_range(12, 1));
         n = int'($urandom_range(k + 6, k));
         abort_at = cyc + k;
         if (n == k) begin
            done_at = cyc + n;
            e.cycles = n + 1;
            e.status = 0;
         end else begin
            e.cycles = k + 1;
            e.status = 2;
         end
         end_exp = 1'b1;
      end else begin
         n = (mode == 1) ? 3 : (mode == 3) ? 5 : (r == 2) ? TIMEOUT - 1 : int'($urandom_range(12, 1));
         done_at = cyc + n;
         e.cycles = n + 1;
         e.status = 0;
      end
      if (idx == batch_runs - 1) end_exp = 1'b1;
      exp_q.push_back(e);
   endtask

   task automatic step();
      ent_t e;
      @(negedge clock);
      cyc++;
      if (start_port) begin
         check("start_allowed", (!end_exp && starts < batch_runs) ? 1 : 0, 1);
         if (starts == 0) check("krst_len_first", (low_run >= RST_CYCLES) ? 1 : 0, 1);
         else check("krst_len", low_run, RST_CYCLES);
         plan_run(starts);
         starts++;
      end
      low_run = kernel_reset_n ? 0 : low_run + 1;
      done_port = (cyc == done_at);
      abort = (cyc == abort_at);
      if (mode == 2 && busy && !kernel_reset_n && !all_done && starts == krst_run && !end_exp) begin
         abort = 1'b1;
         end_exp = 1'b1;
      end
      if (!done_port && !kernel_reset_n && $urandom_range(3) == 0) done_port = 1'b1;
      go = busy && ($urandom_range(7) == 0);
      cfg_runs = RUNS_W'($urandom);
      if (prev_hold) check("head_stable", {res_cycles, res_status, res_run_idx}, prev_head);
      if (force_ready) res_ready = 1'b1;
      else if (mode == 1 && cyc < go_cyc + 50) res_ready = 1'b0;
      else res_ready = ($urandom_range(2) != 0);
      if (res_valid && res_ready) begin
         check("model_has_entry", (exp_q.size() > 0) ? 1 : 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("res_cycles", res_cycles, e.cycles);
            check("res_status", res_status, e.status);
            check("res_run_idx", res_run_idx, e.idx);
         end
      end
      prev_hold = res_valid && !res_ready;
      prev_head = {res_cycles, res_status, res_run_idx};
      if (all_done) begin
         done_seen = 1'b1;
         check("busy_at_done", busy, 1);
         check("done_expected", end_exp, 1);
      end
      if (mode == 1 && cyc == go_cyc + 50) begin
         check("stall_starts", starts, 3);
         check("stall_busy", busy, 1);
      end
   endtask

   task automatic run_batch(input int runs, input int m);
      mode = m;
      batch_runs = runs;
      starts = 0;
      end_exp = (runs == 0);
      done_seen = 1'b0;
      krst_run = (runs > 0) ? int'($urandom_range(runs - 1)) : -1;
      go = 1'b1;
      cfg_runs = RUNS_W'(runs);
      go_cyc = cyc;
      step();
      check("busy_after_go", busy, 1);
      if (runs == 0) check("zero_run_done", all_done, 1);
      for (int i = 0; i < 3000 && !done_seen; i++) step();
      check("batch_end_seen", done_seen, 1);
      step();
      check("busy_cleared", busy, 0);
      check("all_done_single", all_done, 0);
   endtask

   task automatic drain();
      force_ready = 1'b1;
      for (int i = 0; i < 50 && (res_valid || exp_q.size() != 0); i++) step();
      force_ready = 1'b0;
      check("drain_valid", res_valid, 0);
      check("drain_model", exp_q.size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      go = 1'b0;
      abort = 1'b0;
      done_port = 1'b0;
      res_ready = 1'b0;
      cfg_runs = '0;
      #3;
      check_reset_outputs("reset");
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (3) step();

      run_batch(0, 0);
      check("zero_run_no_entry", res_valid, 0);
      run_batch(3, 3);
      run_batch(2, 4);
      drain();
      run_batch(4, 1);
      drain();
      for (int b = 0; b < 12; b++)
         run_batch(int'($urandom_range(6, 1)), ($urandom_range(3) == 0) ? 2 : 0);

      // reset in the middle of a run's WAIT phase
      mode = 3;
      batch_runs = 3;
      starts = 0;
      end_exp = 1'b0;
      done_seen = 1'b0;
      go = 1'b1;
      cfg_runs = RUNS_W'(3);
      step();
      for (int i = 0; i < 20 && starts == 0; i++) step();
      check("reset_test_started", starts, 1);
      repeat (3) step();
      check("reset_test_in_wait", kernel_reset_n, 1);
      go = 1'b0;
      abort = 1'b0;
      done_port = 1'b0;
      #2 reset = 1'b1;
      #1 check_reset_outputs("midrun_reset");
      exp_q.delete();
      done_at = -1;
      abort_at = -1;
      prev_hold = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      run_batch(2, 0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
